// File: rtl/chaos_pkg.sv
// Shared constants and types for the chaos-map keystream path:
// FP32 field layout, the fraction shift origin and the converter state.
package chaos_pkg;

    localparam int EXP_W           = 8;
    localparam int FRAC_W          = 23;
    localparam int BIAS            = 127;
    localparam int FRAC_SHIFT_BASE = 118;
    localparam int UFRAC_W         = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } conv_state_e;

endpackage

// File: rtl/fp32_to_ufrac.sv
// Combinational FP32 -> 32-bit unsigned binary fraction converter.
// Flags anything outside [0,1) (negative, >= 1.0, inf, NaN) as a range error.
module fp32_to_ufrac
    import chaos_pkg::*;
(
    input  logic [EXP_W+FRAC_W:0] x,
    output logic [UFRAC_W-1:0]    frac,
    output logic                  range_err
);

    logic                sign;
    logic [EXP_W-1:0]    expo;
    logic [UFRAC_W-1:0]  mant;

    assign sign = x[EXP_W+FRAC_W];
    assign expo = x[FRAC_W +: EXP_W];
    assign mant = {{(UFRAC_W-FRAC_W-1){1'b0}}, 1'b1, x[FRAC_W-1:0]};

    // frac = mant * 2^(expo - FRAC_SHIFT_BASE); tiny values (incl. zero and
    // denormals) shift completely out and yield 0.
    always_comb begin
        frac      = '0;
        range_err = 1'b0;
        if (sign || (expo >= EXP_W'(BIAS))) begin
            range_err = 1'b1;
        end else if (expo >= EXP_W'(FRAC_SHIFT_BASE)) begin
            frac = mant << (expo - EXP_W'(FRAC_SHIFT_BASE));
        end else if (expo > EXP_W'(FRAC_SHIFT_BASE - UFRAC_W)) begin
            frac = mant >> (EXP_W'(FRAC_SHIFT_BASE) - expo);
        end
    end

endmodule

// File: rtl/sawtooth_keystream.sv
// Turns FP32 chaos samples into key bytes (MSB byte first), buffers them in a
// small FIFO and XORs them onto the pixel stream with frame-last marking.
module sawtooth_keystream
    import chaos_pkg::*;
#(
    parameter int PRECISION        = 32,
    parameter int BYTES_PER_SAMPLE = 2,
    parameter int KEY_DEPTH        = 8,
    parameter int FRAME_PIXELS     = 65536
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 chaos_valid,
    output logic                 chaos_ready,
    input  logic [PRECISION-1:0] x,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [7:0]           pix_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_pix,
    output logic                 out_last,
    output logic                 range_err
);

    localparam int PTR_W = $clog2(KEY_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int K_W   = 2;
    localparam int PIX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

    localparam logic [K_W-1:0]   LAST_K   = K_W'(BYTES_PER_SAMPLE - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIXELS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(KEY_DEPTH);

    // converter
    conv_state_e         state_q, state_d;
    logic [31:0]         frac_q, frac_d;
    logic [K_W-1:0]      k_q, k_d;
    logic                range_err_q, range_err_d;
    logic [31:0]         conv_frac;
    logic                conv_err;

    // key FIFO
    logic [7:0]          mem_q [KEY_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // cipher output register
    logic                out_valid_q, out_valid_d;
    logic [7:0]          out_pix_q, out_pix_d;
    logic                out_last_q, out_last_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;

    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic                last_byte;
    logic                chaos_acc;
    logic [7:0]          push_byte;
    logic [7:0]          fifo_head;
    logic [7:0]          frac_bytes [4];

    fp32_to_ufrac u_conv (
        .x         (x),
        .frac      (conv_frac),
        .range_err (conv_err)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
        assign frac_bytes[gi] = frac_q[31-8*gi -: 8];
    end

    assign push_byte  = frac_bytes[k_q];
    assign fifo_head  = mem_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);

    assign pix_ready  = !fifo_empty && (!out_valid_q || out_ready);
    assign pop        = pix_valid && pix_ready;

    // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
    assign push       = (state_q == EMIT) && (!fifo_full || pop);
    assign last_byte  = (k_q == LAST_K);

    // Ready again on the final push so consecutive samples flow without a bubble.
    assign chaos_ready = (state_q == IDLE) || (push && last_byte);
    assign chaos_acc   = chaos_valid && chaos_ready;

    always_comb begin
        state_d     = state_q;
        frac_d      = frac_q;
        k_d         = k_q;
        range_err_d = 1'b0;
        if (push) begin
            if (last_byte) begin
                state_d = IDLE;
                k_d     = '0;
            end else begin
                k_d = k_q + K_W'(1);
            end
        end
        if (chaos_acc) begin
            range_err_d = conv_err;
            if (!conv_err) begin
                frac_d  = conv_frac;
                state_d = EMIT;
                k_d     = '0;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        out_last_d  = out_last_q;
        pix_cnt_d   = pix_cnt_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_pix_d   = pix_in ^ fifo_head;
            out_last_d  = (pix_cnt_q == LAST_PIX);
            pix_cnt_d   = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + PIX_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            frac_q      <= '0;
            k_q         <= '0;
            range_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_last_q  <= 1'b0;
            pix_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            frac_q      <= frac_d;
            k_q         <= k_d;
            range_err_q <= range_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            out_last_q  <= out_last_d;
            pix_cnt_q   <= pix_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_last  = out_last_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_sawtooth_keystream.sv
// Bench for sawtooth_keystream: directed vector table, hand-written corner
// sequences and randomized traffic checked against a real-arithmetic key model.
module tb_sawtooth_keystream;

    localparam int FRAME = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chaos_valid = 1'b0;
    logic        chaos_ready;
    logic [31:0] x_in = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  pix_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_pix;
    logic        out_last;
    logic        range_err;

    always #5 clk = ~clk;

    sawtooth_keystream #(.FRAME_PIXELS(FRAME)) dut (
        .clk         (clk),
        .reset       (reset),
        .chaos_valid (chaos_valid),
        .chaos_ready (chaos_ready),
        .x           (x_in),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_in      (pix_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pix     (out_pix),
        .out_last    (out_last),
        .range_err   (range_err)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] key_q[$];
    logic [7:0] exp_pix_q[$];
    logic       exp_last_q[$];
    logic [7:0] out_log[$];
    logic       last_log[$];
    logic [7:0] src_q[$];
    logic [7:0] plain_log[$];
    bit         err_expect = 1'b0;
    int         pix_seen = 0;

    typedef struct {
        logic [31:0] x;
        logic [7:0]  p0;
        logic [7:0]  p1;
        logic [7:0]  e0;
        logic [7:0]  e1;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the sample as a real number in [0,1), key word = floor(x * 2^32).
    function automatic void model_conv(input logic [31:0] xv, output bit err, output logic [31:0] f);
        logic [7:0]  e;
        logic [63:0] db;
        real         r;
        e   = xv[30:23];
        err = 1'b0;
        f   = '0;
        if (xv[31] || e == 8'hFF) begin
            err = 1'b1;
        end else begin
            db = {1'b0, 11'(e) + 11'd896, xv[22:0], 29'd0};
            r  = (e == 8'd0) ? 0.0 : $bitstoreal(db);
            if (r >= 1.0) err = 1'b1;
            else f = 32'(longint'($floor(r * 4294967296.0)));
        end
    endfunction

    task automatic model_chaos(input logic [31:0] xv);
        bit          e;
        logic [31:0] f;
        model_conv(xv, e, f);
        err_expect = e;
        if (!e) begin
            for (int b = 0; b < 2; b++) key_q.push_back(8'(f >> (24 - 8 * b)));
        end
    endtask

    task automatic model_pix(input logic [7:0] p);
        if (key_q.size() == 0) begin
            check("key_available", 32'(key_q.size()), 1);
        end else begin
            exp_pix_q.push_back(p ^ key_q.pop_front());
            exp_last_q.push_back((pix_seen % FRAME) == FRAME - 1);
            pix_seen++;
        end
    endtask

    task automatic clear_model();
        key_q.delete();
        exp_pix_q.delete();
        exp_last_q.delete();
        out_log.delete();
        last_log.delete();
        pix_seen   = 0;
        err_expect = 1'b0;
    endtask

    // Output / range_err monitor, sampled mid-low-phase after stimulus settles.
    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (range_err || err_expect) check("range_err", 32'(range_err), 32'(err_expect));
            err_expect = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_pix_q.size() == 0) begin
                    check("out_spurious", 32'(out_valid), 0);
                end else begin
                    check("out_pix", 32'(out_pix), 32'(exp_pix_q.pop_front()));
                    check("out_last", 32'(out_last), 32'(exp_last_q.pop_front()));
                end
                out_log.push_back(out_pix);
                last_log.push_back(out_last);
                $display("out pix=%h last=%0d", out_pix, out_last);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        chaos_valid = 1'b0;
        pix_valid   = 1'b0;
        out_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_pix", 32'(out_pix), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_range_err", 32'(range_err), 0);
        check("rst_chaos_ready", 32'(chaos_ready), 1);
        check("rst_pix_ready", 32'(pix_ready), 0);
        reset = 1'b0;
        clear_model();
        @(negedge clk);
    endtask

    task automatic send_sample(input logic [31:0] xv);
        bit acc;
        int guard;
        acc         = 1'b0;
        guard       = 0;
        chaos_valid = 1'b1;
        x_in        = xv;
        while (!acc && guard < 300) begin
            #1;
            acc = chaos_ready;
            @(posedge clk);
            if (acc) model_chaos(xv);
            @(negedge clk);
            guard++;
        end
        chaos_valid = 1'b0;
        $display("sample x=%h accepted=%0d", xv, acc);
        check("chaos_accept", 32'(acc), 1);
    endtask

    task automatic send_pixels(input int n, input bit rand_rdy);
        for (int i = 0; i < n; i++) begin
            logic [7:0] p;
            bit         acc;
            int         guard;
            p         = (src_q.size() != 0) ? src_q.pop_front() : 8'($urandom);
            acc       = 1'b0;
            guard     = 0;
            pix_valid = 1'b1;
            pix_in    = p;
            while (!acc && guard < 300) begin
                if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
                #1;
                acc = pix_ready;
                @(posedge clk);
                if (acc) begin
                    model_pix(p);
                    plain_log.push_back(p);
                end
                @(negedge clk);
                guard++;
            end
            if (!acc) begin
                check("pix_accept", 32'(acc), 1);
                pix_valid = 1'b0;
                return;
            end
            if (rand_rdy && $urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
                @(negedge clk);
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_pix_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 32'(exp_pix_q.size()), 0);
    endtask

    function automatic logic [31:0] rand_sample(input bit allow_bad);
        logic [31:0] v;
        v = {1'b0, 8'($urandom_range(80, 126)), 23'($urandom)};
        if (allow_bad && $urandom_range(0, 3) == 0) v[31] = 1'b1;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [8];
        logic        last_pat [6];
        logic [31:0] samples [8];
        logic [7:0]  plain_saved[$];
        logic [7:0]  cipher[$];
        int          n_keys;
        bit          e;
        logic [31:0] f;

        vecs[0] = '{32'h3F000000, 8'h00, 8'hFF, 8'h80, 8'hFF};
        vecs[1] = '{32'h3DCCCCCD, 8'h55, 8'h55, 8'h4C, 8'hCC};
        vecs[2] = '{32'h3E800000, 8'h12, 8'h34, 8'h52, 8'h34};
        vecs[3] = '{32'h00000000, 8'hA5, 8'h5A, 8'hA5, 8'h5A};
        vecs[4] = '{32'h3F7FFFFF, 8'h0F, 8'hF0, 8'hF0, 8'h0F};
        vecs[5] = '{32'h38000000, 8'h11, 8'h22, 8'h11, 8'h20};
        vecs[6] = '{32'h3B000000, 8'h00, 8'h00, 8'h00, 8'h80};
        vecs[7] = '{32'h2B800000, 8'h3C, 8'hC3, 8'h3C, 8'hC3};
        last_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // directed conversion vectors
        for (int v = 0; v < 8; v++) begin
            do_reset();
            send_sample(vecs[v].x);
            src_q.delete();
            src_q.push_back(vecs[v].p0);
            src_q.push_back(vecs[v].p1);
            out_ready = 1'b1;
            send_pixels(2, 1'b0);
            drain();
            if (out_log.size() >= 2) begin
                check("vec_out0", 32'(out_log[0]), 32'(vecs[v].e0));
                check("vec_out1", 32'(out_log[1]), 32'(vecs[v].e1));
            end else begin
                check("vec_out_count", 32'(out_log.size()), 2);
            end
        end

        // out-of-range samples: pulses only, no keys
        do_reset();
        send_sample(32'hBF000000);
        #1;
        check("range_pulse_hi", 32'(range_err), 1);
        send_sample(32'h3F800000);
        send_sample(32'h7F800000);
        send_sample(32'h7FC00000);
        send_sample(32'h80000000);
        @(negedge clk);
        #1;
        check("range_pulse_lo", 32'(range_err), 0);
        for (int c = 0; c < 5; c++) begin
            check("range_no_keys", 32'(pix_ready), 32'(key_q.size() != 0));
            @(negedge clk);
            #1;
        end

        // latency, back-to-back samples and frame-last wrap
        do_reset();
        send_sample(32'h3E800000);
        #1;
        check("lat_pix_ready_c1", 32'(pix_ready), 0);
        check("lat_chaos_busy", 32'(chaos_ready), 0);
        @(negedge clk);
        #1;
        check("lat_pix_ready_c2", 32'(pix_ready), 1);
        check("b2b_chaos_ready", 32'(chaos_ready), 1);
        send_sample(rand_sample(1'b0));
        send_sample(rand_sample(1'b0));
        out_ready = 1'b1;
        send_pixels(6, 1'b0);
        drain();
        check("frame_count", 32'(last_log.size()), 6);
        for (int i = 0; i < 6 && i < last_log.size(); i++) check("frame_last_pat", 32'(last_log[i]), 32'(last_pat[i]));

        // reset while the converter is emitting
        do_reset();
        send_sample(32'h3F000000);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        src_q.push_back(8'h11);
        send_pixels(1, 1'b0);
        send_sample(32'h3DCCCCCD);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_pix_ready", 32'(pix_ready), 0);
        check("midrst_chaos_ready", 32'(chaos_ready), 1);
        reset = 1'b0;
        clear_model();
        src_q.delete();
        @(negedge clk);
        send_sample(32'h3F000000);
        src_q.push_back(8'h00);
        src_q.push_back(8'hFF);
        out_ready = 1'b1;
        send_pixels(2, 1'b0);
        drain();
        if (out_log.size() >= 1) check("midrst_fresh_key", 32'(out_log[0]), 32'h80);

        // backpressure: FIFO fills, converter stalls, then stream resumes
        do_reset();
        for (int i = 0; i < 8; i++) samples[i] = rand_sample(1'b0);
        fork
            begin
                for (int i = 0; i < 8; i++) send_sample(samples[i]);
            end
            begin
                repeat (40) @(negedge clk);
                #1;
                check("stall_full", 32'(chaos_ready), 0);
                @(negedge clk);
                send_pixels(16, 1'b1);
            end
        join
        drain();
        check("bp_keys_used", 32'(key_q.size()), 0);
        check("bp_out_count", 32'(out_log.size()), 16);
        #1;
        check("bp_fifo_empty", 32'(pix_ready), 0);

        // encrypt, then decrypt with the same sample sequence
        for (int i = 0; i < 8; i++) samples[i] = rand_sample(1'b1);
        n_keys = 0;
        for (int i = 0; i < 8; i++) begin
            model_conv(samples[i], e, f);
            if (!e) n_keys += 2;
        end
        do_reset();
        plain_log.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) send_sample(samples[i]);
            end
            send_pixels(n_keys, 1'b1);
        join
        drain();
        plain_saved = plain_log;
        cipher      = out_log;
        do_reset();
        src_q = cipher;
        fork
            begin
                for (int i = 0; i < 8; i++) send_sample(samples[i]);
            end
            send_pixels(n_keys, 1'b1);
        join
        drain();
        check("dec_count", 32'(out_log.size()), 32'(plain_saved.size()));
        for (int i = 0; i < out_log.size() && i < plain_saved.size(); i++) begin
            check("dec_recover", 32'(out_log[i]), 32'(plain_saved[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
